// File: rtl/shift_mix_stage.sv
// AES round back half: ShiftRows on accept, then MixColumns one column per cycle
// through a single shared column datapath; result held until the consumer takes it.
module shift_mix_stage (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0][3:0][7:0]  state,
  input  logic                  last_round,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [3:0][3:0][7:0]  o,
  output logic                  o_valid,
  input  logic                  o_ready
);

  localparam int unsigned BW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } fsm_e;

  fsm_e                        fsm_q, fsm_d;
  logic [CW-1:0]               col_q, col_d;
  logic                        last_q, last_d;
  logic [NR-1:0][NR-1:0][BW-1:0] wr_q, wr_d;
  logic                        o_valid_q, o_valid_d;

  logic                        accept;
  logic [NR-1:0][NR-1:0][BW-1:0] sr;
  logic [NR-1:0][BW-1:0]       col_a;
  logic [NR-1:0][BW-1:0]       col_b;
  logic [NR-1:0][BW-1:0]       col_x;

  function automatic logic [BW-1:0] xtime(input logic [BW-1:0] x);
    return {x[BW-2:0], 1'b0} ^ (x[BW-1] ? 8'h1B : 8'h00);
  endfunction

  // Ready is combinational so a HOLD result can hand off to a new input with no bubble.
  assign in_ready = rst & ((fsm_q == IDLE) | ((fsm_q == HOLD) & o_ready));
  assign accept   = in_valid & in_ready;
  assign o        = wr_q;
  assign o_valid  = o_valid_q;

  // ShiftRows: row r rotates left by r bytes.
  always_comb begin
    sr = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NR; c++) begin
        sr[r][c] = state[r][CW'(c + r)];
      end
    end
  end

  // Shared MixColumns datapath on the column selected by col_q.
  always_comb begin
    col_a = '0;
    col_x = '0;
    for (int r = 0; r < NR; r++) begin
      col_a[r] = wr_q[r][col_q];
      col_x[r] = xtime(col_a[r]);
    end
    col_b[0] = col_x[0] ^ (col_x[1] ^ col_a[1]) ^ col_a[2] ^ col_a[3];
    col_b[1] = col_a[0] ^ col_x[1] ^ (col_x[2] ^ col_a[2]) ^ col_a[3];
    col_b[2] = col_a[0] ^ col_a[1] ^ col_x[2] ^ (col_x[3] ^ col_a[3]);
    col_b[3] = (col_x[0] ^ col_a[0]) ^ col_a[1] ^ col_a[2] ^ col_x[3];
  end

  // Next-state and datapath update.
  always_comb begin
    fsm_d     = fsm_q;
    col_d     = col_q;
    last_d    = last_q;
    wr_d      = wr_q;
    o_valid_d = o_valid_q;

    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          wr_d   = sr;
          last_d = last_round;
          col_d  = '0;
          if (last_round) begin
            fsm_d     = HOLD;
            o_valid_d = 1'b1;
          end else begin
            fsm_d     = CALC;
            o_valid_d = 1'b0;
          end
        end
      end
      CALC: begin
        for (int r = 0; r < NR; r++) begin
          wr_d[r][col_q] = col_b[r];
        end
        col_d = col_q + CW'(1);
        if (col_q == CW'(NR - 1)) begin
          fsm_d     = HOLD;
          o_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (o_ready) begin
          if (accept) begin
            wr_d   = sr;
            last_d = last_round;
            col_d  = '0;
            if (last_round) begin
              fsm_d     = HOLD;
              o_valid_d = 1'b1;
            end else begin
              fsm_d     = CALC;
              o_valid_d = 1'b0;
            end
          end else begin
            fsm_d     = IDLE;
            o_valid_d = 1'b0;
          end
        end
      end
      default: begin
        fsm_d     = IDLE;
        o_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= IDLE;
      col_q     <= '0;
      last_q    <= 1'b0;
      wr_q      <= '0;
      o_valid_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      col_q     <= col_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      o_valid_q <= o_valid_d;
    end
  end

endmodule

// File: doc/shift_mix_stage.md
SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 Parameters: none; byte width fixed at 8, state fixed at 4x4 bytes, indexed [row][col].
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 state  in  4x4x8  SubBytes result for the current round.
REQ-005 last_round  in  1  1 = final AES round: skip MixColumns.
REQ-006 in_valid  in  1  state/last_round valid.
REQ-007 in_ready  out  1  stage can accept; transfer occurs when in_valid & in_ready at a rising edge.
REQ-008 o  out  4x4x8  ShiftRows(+MixColumns) result.
REQ-009 o_valid  out  1  o holds a completed result.
REQ-010 o_ready  in  1  consumer accepts o; transfer occurs when o_valid & o_ready at a rising edge.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and HOLD, plus a 2-bit column counter col and a 4x4x8 working register wr driving o.
REQ-012 in_ready SHALL be 1 in IDLE, (o_ready) in HOLD, 0 in CALC, and 0 while rst is low.
REQ-013 On accept, wr SHALL load ShiftRows(state): wr[r][c] = state[r][(c+r) mod 4]; last_round is latched with it.
REQ-014 On accept with last_round=1, the next state SHALL be HOLD, so o_valid rises 1 cycle after the accepting edge.
REQ-015 On accept with last_round=0, the next state SHALL be CALC with col=0.
REQ-016 In CALC, each edge SHALL replace column col of wr with MixColumns of that column and increment col; the edge processing col=3 SHALL move to HOLD. o_valid therefore rises 5 edges after accept (4 CALC cycles).
REQ-017 MixColumns per column (a0..a3 -> b0..b3), GF(2^8) with xtime(x) = (x<<1 mod 256) xor (x[7] ? 0x1B : 0x00):
- b0 = 2a0^3a1^a2^a3
- b1 = a0^2a1^3a2^a3
- b2 = a0^a1^2a2^3a3
- b3 = 3a0^a1^a2^2a3
- 3x = xtime(x)^x
REQ-018 Only one MixColumns column datapath SHALL be instantiated; it is shared across the 4 CALC cycles.
REQ-019 In HOLD, o_valid SHALL be 1 and o SHALL stay stable until the o transfer.
REQ-020 HOLD with o_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-021 HOLD with o_ready=1 and in_valid=1 SHALL complete the output transfer and accept the new input on the same edge, continuing per REQ-013 to REQ-015 with no bubble.
REQ-022 o_valid SHALL be 0 in IDLE and CALC; o shows wr at all times; its contents are defined only when o_valid=1.
REQ-023 Changes on state/last_round while not accepting SHALL have no effect.
REQ-024 col SHALL wrap from 3 to 0; col is don't-care outside CALC.

Reset
REQ-025 rst low SHALL asynchronously force: FSM to IDLE, col=0, latched last_round=0, wr all 0x00 (so o = 0x00), o_valid=0.
REQ-026 Reset asserted mid-CALC or in HOLD SHALL abort the operation with no output transfer; after rst rises, the first accept behaves as from a cold reset.

Verification
REQ-027 FIPS-197 round 1, last_round=0, rows {d4 e0 b8 1e},{27 bf b4 41},{11 98 5d 52},{ae f1 e5 30} -> o_valid 5 edges after accept, o rows {04 e0 48 28},{66 cb f8 06},{81 19 d3 26},{e5 9a 7a 4c}.
REQ-028 Same input with last_round=1 -> o_valid 1 edge after accept, o rows {d4 e0 b8 1e},{bf b4 41 27},{5d 52 11 98},{30 ae f1 e5}.
REQ-029 Back-pressure: hold o_ready=0 for 10 cycles in HOLD -> o and o_valid stable and in_ready=0; then o_ready=1 with in_valid=1 -> output and input transfer on the same edge, and the next result follows per REQ-016.
REQ-030 Column all 0x80 (xtime carry path) -> column all 0x80 (2x^3x^x^x = x).
REQ-031 Assert rst on the 2nd CALC cycle -> o_valid=0 and o=0x00 immediately; a new FIPS vector after release -> correct result per REQ-027.
REQ-032 Random streams with random in_valid/o_ready, checked against a reference model -> no lost or duplicated results, outputs in accept order.
